// File: rtl/factorial_ctrl.sv
// factorial_ctrl: sequencing controller for the factorial datapath.
// Drives the counter/accumulator load and update strobes, iterating
// acc <= acc * cnt, cnt <= cnt - 1 until the datapath reports cnt <= 1.
// Optional feature macro: FACT_RANGE_CHECK_EN (rejects n > 12 through ERR).
// All outputs are registered and decoded from the state being entered.
module factorial_ctrl #(
   parameter int ITER_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [31:0]       n,
   input  logic              le_one,
   output logic              ld_n,
   output logic              ld_acc,
   output logic              acc_sel,
   output logic              dec_n,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ITER_W-1:0] iter
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_CHECK = 3'd2,
      S_MUL   = 3'd3,
`ifdef FACT_RANGE_CHECK_EN
      S_ERR   = 3'd5,
`endif
      S_DONE  = 3'd4
   } state_t;

   // 12! is the largest factorial representable in 32 bits
   localparam logic [31:0] N_MAX = 32'd12;

   state_t            r_state;
   logic              r_ld_n;
   logic              r_ld_acc;
   logic              r_acc_sel;
   logic              r_dec_n;
   logic              r_busy;
   logic              r_done;
   logic [ITER_W-1:0] r_iter;

`ifdef FACT_RANGE_CHECK_EN
   logic              r_err;
   logic              w_out_of_range;

   assign w_out_of_range = (n > N_MAX);
   assign err            = r_err;
`else
   // Without the range check the operand only matters to the datapath
   logic              w_n_unused;

   assign w_n_unused = ^{n, N_MAX};
   assign err        = 1'b0;
`endif

   // Controller FSM: next state plus registered Moore strobes for that state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_ld_n    <= 1'b0;
         r_ld_acc  <= 1'b0;
         r_acc_sel <= 1'b0;
         r_dec_n   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_iter    <= '0;
`ifdef FACT_RANGE_CHECK_EN
         r_err     <= 1'b0;
`endif
      end else begin
         // Strobes are single-state pulses; each transition re-asserts what it needs
         r_ld_n    <= 1'b0;
         r_ld_acc  <= 1'b0;
         r_acc_sel <= 1'b0;
         r_dec_n   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
`ifdef FACT_RANGE_CHECK_EN
                  if (w_out_of_range) begin
                     r_state <= S_ERR;
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                  end else begin
                     r_state  <= S_LOAD;
                     r_ld_n   <= 1'b1;
                     r_ld_acc <= 1'b1;
                     r_busy   <= 1'b1;
                     r_err    <= 1'b0;
                  end
`else
                  r_state  <= S_LOAD;
                  r_ld_n   <= 1'b1;
                  r_ld_acc <= 1'b1;
                  r_busy   <= 1'b1;
`endif
               end
            end
            S_LOAD: begin
               // cnt <= n and acc <= 1 happen on this edge in the datapath
               r_iter  <= '0;
               r_state <= S_CHECK;
               r_busy  <= 1'b1;
            end
            S_CHECK: begin
               if (le_one) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state   <= S_MUL;
                  r_ld_acc  <= 1'b1;
                  r_acc_sel <= 1'b1;
                  r_dec_n   <= 1'b1;
                  r_busy    <= 1'b1;
               end
            end
            S_MUL: begin
               if (r_iter != {ITER_W{1'b1}}) begin
                  r_iter <= r_iter + 1'b1;
               end
               r_state <= S_CHECK;
               r_busy  <= 1'b1;
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
`ifdef FACT_RANGE_CHECK_EN
            S_ERR: begin
               r_state <= S_IDLE;
            end
`endif
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign ld_n    = r_ld_n;
   assign ld_acc  = r_ld_acc;
   assign acc_sel = r_acc_sel;
   assign dec_n   = r_dec_n;
   assign busy    = r_busy;
   assign done    = r_done;
   assign iter    = r_iter;

endmodule
